msg_router: RTL

MSG_ROUTER -- requirements
Module: msg_router

---
 rtl/msg_pkg.sv | 36 +++
 rtl/msg_fifo.sv | 82 ++++++++
 rtl/msg_router.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// ---------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the message router: message type codes, router
// FSM state encoding and helpers that derive the message field widths
// from the router parameters.
// ---------------------------------------------------------------------------
package msg_pkg;

  // Message type codes carried in the top four bits of every message.
  // MSG_BCAST is the only code the router treats specially.
  typedef enum logic [3:0] {
    MSG_READ  = 4'h1,
    MSG_WRITE = 4'h2,
    MSG_INV   = 4'h3,
    MSG_ACK   = 4'h4,
    MSG_BCAST = 4'hF
  } msg_type_e;

  // Router delivery states.
  typedef enum logic [1:0] {
    IDLE,
    UNICAST,
    BCAST
  } router_state_e;

  // Width of a cache id (src/dst fields).
  function automatic int id_width(input int cache_num);
    return $clog2(cache_num);
  endfunction

  // Full message width: type + src + dst + address.
  function automatic int msg_width(input int cache_num, input int addr_width);
    return 4 + 2 * $clog2(cache_num) + addr_width;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// ---------------------------------------------------------------------------
// msg_fifo
// Message FIFO with storage, wrapping pointers and an occupancy count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid/i_data  incoming message; accepted when not full or when a
//                   pop happens in the same cycle, otherwise dropped
//   i_pop           remove the head (ignored while empty)
//   o_next_head     message that will be at the head after this edge
//   o_next_empty    FIFO will be empty after this edge
//   o_count         current occupancy
//   o_almost_full   registered (count >= DEPTH-2)
//   o_drop          incoming message is being discarded this cycle
// ---------------------------------------------------------------------------
module msg_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_next_head,
  output logic              o_next_empty,
  output logic [CW-1:0]     o_count,
  output logic              o_almost_full,
  output logic              o_drop
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              r_almost_full;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rd_next;
  logic [CW-1:0]     w_count_next;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = i_pop & ~w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push       = i_valid & (~w_full | w_pop);
  assign o_drop       = i_valid & w_full & ~w_pop;
  assign w_rd_next    = r_rd + AW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign o_next_empty = (w_count_next == '0);
  // When the next read slot is the one being written right now, the new
  // head is the incoming message rather than stale storage.
  assign o_next_head  = (w_push && (w_rd_next == r_wr)) ? i_data : r_mem[w_rd_next];

  assign o_count       = r_count;
  assign o_almost_full = r_almost_full;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd          <= w_rd_next;
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= CW'(DEPTH - 2));
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/msg_router.sv
// ---------------------------------------------------------------------------
// msg_router
// Buffers arbitrated coherence messages in a FIFO and delivers the head to
// one cache (unicast) or to every cache except the sender (broadcast).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   msg_in_valid      message present (no back-pressure)
//   msg_in            message {type, src, dst, addr}
//   msg_dst_valid     per-cache delivery valid
//   msg_dst_ready     per-cache delivery ready
//   msg_dst           delivered message, shared by all caches
//   fifo_almost_full  upstream must stop requesting while high
//   fifo_count        FIFO occupancy
//   overflow_err      sticky: a message was dropped
// ---------------------------------------------------------------------------
module msg_router
  import msg_pkg::*;
#(
  parameter int  cache_num  = 2,
  parameter int  addr_width = 32,
  parameter int  fifo_depth = 8,
  localparam int MSG_W      = msg_width(cache_num, addr_width),
  localparam int ID_W       = id_width(cache_num),
  localparam int CW         = $clog2(fifo_depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 msg_in_valid,
  input  logic [MSG_W-1:0]     msg_in,
  output logic [cache_num-1:0] msg_dst_valid,
  input  logic [cache_num-1:0] msg_dst_ready,
  output logic [MSG_W-1:0]     msg_dst,
  output logic                 fifo_almost_full,
  output logic [CW-1:0]        fifo_count,
  output logic                 overflow_err
);

  router_state_e        r_state;
  logic [cache_num-1:0] r_dst_valid;
  logic [MSG_W-1:0]     r_msg_dst;
  logic [ID_W-1:0]      r_cur_dst;
  logic                 r_cur_ok;
  logic                 r_ovf;

  logic                 w_pop;
  logic                 w_reload;
  logic                 w_drop;
  logic [MSG_W-1:0]     w_next_head;
  logic                 w_next_empty;
  logic [3:0]           w_nh_type;
  logic [ID_W-1:0]      w_nh_src;
  logic [ID_W-1:0]      w_nh_dst;
  logic                 w_nh_dst_ok;
  logic [cache_num-1:0] w_onehot;
  logic [cache_num-1:0] w_bmask;

  msg_fifo #(
    .DATA_W (MSG_W),
    .DEPTH  (fifo_depth)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (msg_in_valid),
    .i_data        (msg_in),
    .i_pop         (w_pop),
    .o_next_head   (w_next_head),
    .o_next_empty  (w_next_empty),
    .o_count       (fifo_count),
    .o_almost_full (fifo_almost_full),
    .o_drop        (w_drop)
  );

  assign w_nh_type = w_next_head[MSG_W-1 -: 4];
  assign w_nh_src  = w_next_head[MSG_W-5 -: ID_W];
  assign w_nh_dst  = w_next_head[addr_width +: ID_W];

  // Decode the upcoming head into its unicast one-hot target and its
  // broadcast mask (everyone but the sender).
  always_comb begin
    w_nh_dst_ok = (int'(w_nh_dst) < cache_num);
    w_onehot    = '0;
    if (w_nh_dst_ok) w_onehot[w_nh_dst] = 1'b1;
    w_bmask     = '1;
    if (int'(w_nh_src) < cache_num) w_bmask[w_nh_src] = 1'b0;
  end

  // Head pops when its delivery completes; an undeliverable unicast pops
  // straight away. In broadcast, the valid vector is the pending mask, so
  // the head goes once every still-pending bit is ready.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      UNICAST: w_pop = r_cur_ok ? (r_dst_valid[r_cur_dst] & msg_dst_ready[r_cur_dst]) : 1'b1;
      BCAST:   w_pop = ((r_dst_valid & ~msg_dst_ready) == '0);
      default: w_pop = 1'b0;
    endcase
  end

  assign w_reload = (r_state == IDLE) | w_pop;

  // Delivery FSM. Whenever the current head is finished (or nothing is in
  // flight) the state and outputs are loaded from the head that will be
  // present after this edge, which keeps back-to-back delivery at one
  // message per cycle without bypassing the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dst_valid <= '0;
      r_msg_dst   <= '0;
      r_cur_dst   <= '0;
      r_cur_ok    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_reload) begin
        if (w_next_empty) begin
          r_state     <= IDLE;
          r_dst_valid <= '0;
        end else if (w_nh_type == MSG_BCAST) begin
          r_state     <= BCAST;
          r_dst_valid <= w_bmask;
          r_msg_dst   <= w_next_head;
        end else begin
          r_state     <= UNICAST;
          r_dst_valid <= w_onehot;
          r_cur_dst   <= w_nh_dst;
          r_cur_ok    <= w_nh_dst_ok;
          if (w_nh_dst_ok) r_msg_dst <= w_next_head;
        end
      end else if (r_state == BCAST) begin
        r_dst_valid <= r_dst_valid & ~msg_dst_ready;
      end
    end
  end

  assign msg_dst_valid = r_dst_valid;
  assign msg_dst       = r_msg_dst;
  assign overflow_err  = r_ovf;

endmodule
